// File: rtl/sme_sched.sv
// sme_sched: round-robin scheduler feeding string/pattern segments from two requesters to an SME engine.
// Defining SME_SCHED_TIMEOUT_EN adds a 1023-cycle watchdog on the engine result wait.
module sme_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  in_valid,
  output logic [1:0]  in_ready,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_kind,
  input  logic [1:0]  in_last,
  output logic [1:0]  res_valid,
  input  logic [1:0]  res_ready,
  output logic        res_match,
  output logic [4:0]  res_index,
  output logic        res_err,
  output logic [7:0]  chardata,
  output logic        isstring,
  output logic        ispattern,
  input  logic        valid,
  input  logic        match,
  input  logic [4:0]  match_index,
  output logic        proto_err
);
  typedef enum logic [2:0] {IDLE, STREAM, DRAIN, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        rr_q, rr_d;
  logic        str_owner_q, str_owner_d;
  logic        str_owner_valid_q, str_owner_valid_d;
  logic        in_seg_q, in_seg_d;
  logic        seg_kind_q, seg_kind_d;
  logic [1:0]  in_ready_q, in_ready_d;
  logic [1:0]  res_valid_q, res_valid_d;
  logic        res_match_q, res_match_d;
  logic [4:0]  res_index_q, res_index_d;
  logic        res_err_q, res_err_d;
  logic [7:0]  chardata_q, chardata_d;
  logic        isstring_q, isstring_d;
  logic        ispattern_q, ispattern_d;
  logic        proto_err_q, proto_err_d;
`ifdef SME_SCHED_TIMEOUT_EN
  logic [9:0]  wait_cnt_q, wait_cnt_d;
`endif

  logic        cur_kind, cur_last, xfer, owner_ok;
  logic [7:0]  cur_data;
  logic [1:0]  gnt_oh;

  always_comb begin
    cur_kind = in_kind[gnt_q];
    cur_last = in_last[gnt_q];
    cur_data = gnt_q ? in_data[15:8] : in_data[7:0];
    xfer     = in_valid[gnt_q] & in_ready_q[gnt_q];
    owner_ok = str_owner_valid_q & (str_owner_q == gnt_q);
    gnt_oh   = gnt_q ? 2'b10 : 2'b01;
  end

  always_comb begin
    state_d           = state_q;
    gnt_d             = gnt_q;
    rr_d              = rr_q;
    str_owner_d       = str_owner_q;
    str_owner_valid_d = str_owner_valid_q;
    in_seg_d          = in_seg_q;
    seg_kind_d        = seg_kind_q;
    res_valid_d       = res_valid_q;
    res_match_d       = res_match_q;
    res_index_d       = res_index_q;
    res_err_d         = res_err_q;
    chardata_d        = chardata_q;
    isstring_d        = 1'b0;
    ispattern_d       = 1'b0;
    proto_err_d       = proto_err_q | (valid & (state_q != WAIT));
`ifdef SME_SCHED_TIMEOUT_EN
    wait_cnt_d        = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|in_valid) begin
          gnt_d    = in_valid[rr_q] ? rr_q : ~rr_q;
          rr_d     = ~gnt_d;
          in_seg_d = 1'b0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (in_seg_q && (cur_kind != seg_kind_q)) proto_err_d = 1'b1;
          seg_kind_d = cur_kind;
          in_seg_d   = ~cur_last;
          if (!cur_kind) begin
            chardata_d        = cur_data;
            isstring_d        = 1'b1;
            str_owner_d       = gnt_q;
            str_owner_valid_d = 1'b1;
          end else if (owner_ok) begin
            chardata_d  = cur_data;
            ispattern_d = 1'b1;
            if (cur_last) state_d = WAIT;
          end else if (cur_last) begin
            // Rejected single-byte pattern: nothing to drain, answer at once.
            res_valid_d = gnt_oh;
            res_match_d = 1'b0;
            res_index_d = '0;
            res_err_d   = 1'b1;
            state_d     = RESP;
          end else begin
            state_d = DRAIN;
          end
        end else if (in_seg_q) begin
          proto_err_d = 1'b1;
        end
      end
      DRAIN: begin
        if (xfer) begin
          if (cur_last) begin
            in_seg_d    = 1'b0;
            res_valid_d = gnt_oh;
            res_match_d = 1'b0;
            res_index_d = '0;
            res_err_d   = 1'b1;
            state_d     = RESP;
          end
        end else if (in_seg_q) begin
          proto_err_d = 1'b1;
        end
      end
      WAIT: begin
`ifdef SME_SCHED_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 10'd1;
`endif
        if (valid) begin
          res_valid_d = gnt_oh;
          res_match_d = match;
          res_index_d = match_index;
          res_err_d   = 1'b0;
          state_d     = RESP;
        end
`ifdef SME_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == 10'd1022) begin
          res_valid_d       = gnt_oh;
          res_match_d       = 1'b0;
          res_index_d       = '0;
          res_err_d         = 1'b1;
          str_owner_valid_d = 1'b0;
          state_d           = RESP;
        end
`endif
      end
      RESP: begin
        if (res_ready[gnt_q]) begin
          res_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered ready follows the state being entered, so it is valid from the first STREAM cycle.
    if ((state_d == STREAM) || (state_d == DRAIN)) in_ready_d = gnt_d ? 2'b10 : 2'b01;
    else                                             in_ready_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      gnt_q             <= 1'b0;
      rr_q              <= 1'b0;
      str_owner_q       <= 1'b0;
      str_owner_valid_q <= 1'b0;
      in_seg_q          <= 1'b0;
      seg_kind_q        <= 1'b0;
      in_ready_q        <= '0;
      res_valid_q       <= '0;
      res_match_q       <= 1'b0;
      res_index_q       <= '0;
      res_err_q         <= 1'b0;
      chardata_q        <= '0;
      isstring_q        <= 1'b0;
      ispattern_q       <= 1'b0;
      proto_err_q       <= 1'b0;
`ifdef SME_SCHED_TIMEOUT_EN
      wait_cnt_q        <= '0;
`endif
    end else begin
      state_q           <= state_d;
      gnt_q             <= gnt_d;
      rr_q              <= rr_d;
      str_owner_q       <= str_owner_d;
      str_owner_valid_q <= str_owner_valid_d;
      in_seg_q          <= in_seg_d;
      seg_kind_q        <= seg_kind_d;
      in_ready_q        <= in_ready_d;
      res_valid_q       <= res_valid_d;
      res_match_q       <= res_match_d;
      res_index_q       <= res_index_d;
      res_err_q         <= res_err_d;
      chardata_q        <= chardata_d;
      isstring_q        <= isstring_d;
      ispattern_q       <= ispattern_d;
      proto_err_q       <= proto_err_d;
`ifdef SME_SCHED_TIMEOUT_EN
      wait_cnt_q        <= wait_cnt_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_match = res_match_q;
  assign res_index = res_index_q;
  assign res_err   = res_err_q;
  assign chardata  = chardata_q;
  assign isstring  = isstring_q;
  assign ispattern = ispattern_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sme_sched.sv
// Self-checking bench for sme_sched: job-level reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_sme_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid, in_ready, in_kind, in_last, res_valid, res_ready;
  logic [15:0] in_data;
  logic        res_match, res_err, isstring, ispattern, valid, match, proto_err;
  logic [4:0]  res_index, match_index;
  logic [7:0]  chardata;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;
  int str_cnt = 0;
  int pat_cnt = 0;

  always #5 clk = ~clk;

  sme_sched dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kind(in_kind), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_match(res_match), .res_index(res_index), .res_err(res_err),
    .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
    .valid(valid), .match(match), .match_index(match_index),
    .proto_err(proto_err)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endfunction

  function automatic void tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", nm, $time);
  endfunction

  // ---------------- reference model (job level) ----------------
  logic [1:0] e_in_ready = '0, e_res_valid = '0;
  logic       e_res_match = 0, e_res_err = 0, e_isstring = 0, e_ispattern = 0, e_proto = 0;
  logic [4:0] e_res_index = '0;
  logic [7:0] e_char = '0;
  bit   m_busy = 0, m_feeding = 0, m_discard = 0, m_engine = 0, m_result = 0;
  bit   m_mid = 0, m_mid_kind = 0, m_owner_valid = 0, m_k, m_l;
  int   m_id = 0, m_pref = 0, m_owner = 0, m_wait = 0;
  logic [7:0] m_d;

  function void model_result(input logic mm, input logic [4:0] mi, input logic me);
    e_res_valid = (m_id == 1) ? 2'b10 : 2'b01;
    e_res_match = mm;
    e_res_index = mi;
    e_res_err   = me;
    m_feeding = 0;
    m_engine  = 0;
    m_result  = 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_in_ready = '0; e_res_valid = '0; e_res_match = 0; e_res_index = '0; e_res_err = 0;
      e_isstring = 0; e_ispattern = 0; e_proto = 0; e_char = '0;
      m_busy = 0; m_feeding = 0; m_discard = 0; m_engine = 0; m_result = 0;
      m_mid = 0; m_owner_valid = 0; m_pref = 0; m_wait = 0;
    end else begin
      e_isstring = 0;
      e_ispattern = 0;
      if (valid && !m_engine) e_proto = 1;
      if (!m_busy) begin
        if (in_valid != 2'b00) begin
          m_id = in_valid[m_pref] ? m_pref : 1 - m_pref;
          m_pref = 1 - m_id;
          m_busy = 1; m_feeding = 1; m_discard = 0; m_mid = 0;
        end
      end else if (m_feeding) begin
        if (in_valid[m_id]) begin
          m_k = in_kind[m_id];
          m_l = in_last[m_id];
          m_d = in_data[m_id*8 +: 8];
          if (m_discard) begin
            if (m_l) model_result(0, 5'd0, 1);
          end else begin
            if (m_mid && (m_k != m_mid_kind)) e_proto = 1;
            if (!m_k) begin
              e_isstring = 1; e_char = m_d; m_owner = m_id; m_owner_valid = 1;
            end else if (m_owner_valid && m_owner == m_id) begin
              e_ispattern = 1; e_char = m_d;
              if (m_l) begin m_feeding = 0; m_engine = 1; m_wait = 0; end
            end else if (m_l) begin
              model_result(0, 5'd0, 1);
            end else begin
              m_discard = 1;
            end
          end
          m_mid = !m_l;
          m_mid_kind = m_k;
        end else if (m_mid) begin
          e_proto = 1;
        end
      end else if (m_engine) begin
        if (valid) model_result(match, match_index, 0);
`ifdef SME_SCHED_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == 1023) begin model_result(0, 5'd0, 1); m_owner_valid = 0; end
        end
`endif
      end else if (m_result) begin
        if (res_ready[m_id]) begin e_res_valid = '0; m_result = 0; m_busy = 0; end
      end
      e_in_ready = (m_busy && m_feeding) ? ((m_id == 1) ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  always @(negedge clk) begin
    if (isstring === 1'b1) str_cnt++;
    if (ispattern === 1'b1) pat_cnt++;
    if (cmp_on) begin
      chk("in_ready", in_ready, e_in_ready);
      chk("res_valid", res_valid, e_res_valid);
      chk("isstring", isstring, e_isstring);
      chk("ispattern", ispattern, e_ispattern);
      chk("proto_err", proto_err, e_proto);
      if (e_isstring || e_ispattern) chk("chardata", chardata, e_char);
      if (e_res_valid != 2'b00) begin
        chk("res_match", res_match, e_res_match);
        chk("res_index", res_index, e_res_index);
        chk("res_err", res_err, e_res_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int id, input bit kind, input bit last, input logic [7:0] d);
    int n = 0;
    in_valid[id] = 1'b1; in_kind[id] = kind; in_last[id] = last; in_data[id*8 +: 8] = d;
    forever begin
      @(negedge clk);
      if (in_ready[id]) begin @(posedge clk); #1; break; end
      n++;
      if (n > 200) begin tmo("send"); break; end
    end
  endtask

  task automatic drop(input int id);
    in_valid[id] = 1'b0; in_last[id] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic engine(input logic m, input logic [4:0] idx);
    idle_cycles(3);
    valid = 1'b1; match = m; match_index = idx;
    idle_cycles(1);
    valid = 1'b0; match = 1'b0; match_index = '0;
  endtask

  task automatic take(input int id, input logic em, input logic [4:0] ei, input logic ee);
    int n = 0;
    forever begin
      @(negedge clk);
      if (res_valid[id]) break;
      n++;
      if (n > 3000) begin tmo("res_valid"); return; end
    end
    chk("lit_res_match", res_match, em);
    chk("lit_res_index", res_index, ei);
    chk("lit_res_err", res_err, ee);
    res_ready[id] = 1'b1;
    idle_cycles(1);
    res_ready[id] = 1'b0;
  endtask

  task automatic job_to_wait(input int id);
    send(id, 0, 1, "s");
    send(id, 1, 1, "t");
    drop(id);
  endtask

  initial begin
    int s0, p0, n;
    reset = 1'b1;
    in_valid = '0; in_kind = '0; in_last = '0; in_data = '0; res_ready = '0;
    valid = 1'b0; match = 1'b0; match_index = '0;
    @(posedge clk); #1;
    cmp_on = 1;
    @(negedge clk);
    chk("lit_reset_in_ready", in_ready, 2'b00);
    chk("lit_reset_res_valid", res_valid, 2'b00);
    chk("lit_reset_quals", {isstring, ispattern, proto_err}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Requester 1 waits with a pattern byte while requester 0 runs a full job.
    in_valid[1] = 1'b1; in_kind[1] = 1'b1; in_last[1] = 1'b0; in_data[15:8] = "a";
    s0 = str_cnt; p0 = pat_cnt;
    send(0, 0, 0, "a"); send(0, 0, 0, "b"); send(0, 0, 0, "c"); send(0, 0, 0, "d");
    send(0, 0, 1, "e");
    send(0, 1, 0, "c"); send(0, 1, 1, "d");
    drop(0);
    engine(1, 5'd2);
    take(0, 1, 5'd2, 0);
    chk("lit_str_pulses_abcde", str_cnt - s0, 5);
    chk("lit_pat_pulses_cd", pat_cnt - p0, 2);
    @(negedge clk);
    chk("lit_idle_after_resp", in_ready, 2'b00);
    @(negedge clk);
    chk("lit_grant_r1", in_ready, 2'b10);
    p0 = pat_cnt;
    @(posedge clk); #1;
    send(1, 1, 1, "b");
    drop(1);
    take(1, 0, 5'd0, 1);
    chk("lit_no_pattern_fwd", pat_cnt - p0, 0);

    // String with a two-cycle bubble after the first byte.
    s0 = str_cnt;
    send(0, 0, 0, "p");
    drop(0);
    idle_cycles(2);
    send(0, 0, 0, "q"); send(0, 0, 1, "r");
    send(0, 1, 1, "x");
    drop(0);
    chk("lit_proto_gap", proto_err, 1);
    chk("lit_str_pulses_gap", str_cnt - s0, 3);
    engine(0, 5'd7);
    take(0, 0, 5'd7, 0);

    job_to_wait(1);
`ifdef SME_SCHED_TIMEOUT_EN
    n = 0;
    while (n < 1100) begin
      @(negedge clk);
      if (res_valid[1]) break;
      n++;
    end
    chk("lit_timeout_cycles", n, 1023);
    take(1, 0, 5'd0, 1);
`else
    idle_cycles(1100);
    chk("lit_wait_no_timeout", res_valid, 2'b00);
    engine(0, 5'd0);
    take(1, 0, 5'd0, 0);
`endif
    job_to_wait(0);
    idle_cycles(2);
    reset = 1'b1;
    #1;
    chk("lit_rst_in_ready", in_ready, 2'b00);
    chk("lit_rst_res_valid", res_valid, 2'b00);
    chk("lit_rst_proto", proto_err, 0);
    chk("lit_rst_chardata", chardata, 8'h00);
    chk("lit_rst_res_fields", {res_match, res_err, res_index}, 7'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Both request after reset; a kind change without in_last mid-segment.
    in_valid[1] = 1'b1; in_kind[1] = 1'b0; in_last[1] = 1'b1; in_data[15:8] = "w";
    in_valid[0] = 1'b1; in_kind[0] = 1'b0; in_last[0] = 1'b0; in_data[7:0] = "k";
    @(posedge clk); #1;
    @(negedge clk);
    chk("lit_grant_r0_after_reset", in_ready, 2'b01);
    @(posedge clk); #1;
    send(0, 1, 1, "m");
    drop(0);
    chk("lit_proto_kind", proto_err, 1);
    engine(1, 5'd31);
    take(0, 1, 5'd31, 0);
    send(1, 0, 1, "w");
    send(1, 1, 1, "w");
    drop(1);
    engine(0, 5'd0);
    take(1, 0, 5'd0, 0);

    // Engine strobe while idle.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("lit_proto_cleared", proto_err, 0);
    valid = 1'b1;
    idle_cycles(1);
    valid = 1'b0;
    @(negedge clk);
    chk("lit_proto_stray_valid", proto_err, 1);
    chk("lit_stray_no_result", res_valid, 2'b00);
    idle_cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
